// File: rtl/gpio_pad_pkg.sv
// Shared mode encodings and the per-pin mode-to-pad-drive mapping for the GPIO pad bank.
package gpio_pad_pkg;

    localparam logic [1:0] MODE_INPUT     = 2'b00;
    localparam logic [1:0] MODE_PUSHPULL  = 2'b01;
    localparam logic [1:0] MODE_OPENDRAIN = 2'b10;

    typedef struct packed {
        logic o;
        logic t;
    } pad_drive_t;

    // Open-drain only ever pulls low; the high level comes from the external pull-up.
    function automatic pad_drive_t pad_drive(input logic [1:0] mode,
                                             input logic       wr,
                                             input logic       we);
        pad_drive_t d;
        d.o = 1'b0;
        d.t = 1'b1;
        case (mode)
            MODE_PUSHPULL: begin
                d.o = wr;
                d.t = ~we;
            end
            MODE_OPENDRAIN: begin
                d.o = 1'b0;
                d.t = ~(we & ~wr);
            end
            default: begin
                d.o = 1'b0;
                d.t = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/gpio_pad_filter.sv
// One pin's input synchroniser and glitch filter: a level is accepted only after it
// has differed from the filtered value for N consecutive synchronised samples.
module gpio_pad_filter
    import gpio_pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pad_i,
    input  logic [FILTER_BITS-1:0] thresh_i,
    output logic                   filt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   filt_q, filt_d;
    logic [FILTER_BITS-1:0] cnt_q, cnt_d;
    logic [FILTER_BITS-1:0] last_cnt;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign filt_o = filt_q;

    // A threshold of 0 behaves as 1; >= lets a lowered threshold fire on the next differing sample.
    always_comb begin
        last_cnt = (thresh_i == '0) ? '0 : thresh_i - FILTER_BITS'(1);
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        if (sync_s == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q >= last_cnt) begin
            filt_d = sync_s;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + FILTER_BITS'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: registered IOBUF drive per pin mode, filtered pad readback and
// sticky edge interrupts with a combined registered interrupt line.
module gpio_pad_bank
    import gpio_pad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 4
) (
    input  logic                   io_sys_clock,
    input  logic                   io_sys_reset,
    input  logic [WIDTH-1:0]       pins_write,
    input  logic [WIDTH-1:0]       pins_writeEnable,
    output logic [WIDTH-1:0]       pins_read,
    input  logic [2*WIDTH-1:0]     cfg_mode,
    input  logic [FILTER_BITS-1:0] cfg_filter,
    input  logic [WIDTH-1:0]       cfg_irq_rise,
    input  logic [WIDTH-1:0]       cfg_irq_fall,
    input  logic [WIDTH-1:0]       irq_clear,
    output logic [WIDTH-1:0]       irq_pending,
    output logic                   irq,
    input  logic [WIDTH-1:0]       pad_i,
    output logic [WIDTH-1:0]       pad_o,
    output logic [WIDTH-1:0]       pad_t
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d_q;
    logic [WIDTH-1:0] pad_o_q, pad_o_d;
    logic [WIDTH-1:0] pad_t_q, pad_t_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] rise, fall, set;

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        gpio_pad_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_BITS(FILTER_BITS)
        ) u_filter (
            .clk_i   (io_sys_clock),
            .rst_ni  (io_sys_reset),
            .pad_i   (pad_i[g]),
            .thresh_i(cfg_filter),
            .filt_o  (filt[g])
        );

        assign {pad_o_d[g], pad_t_d[g]} =
            pad_drive(cfg_mode[2*g +: 2], pins_write[g], pins_writeEnable[g]);
    end

    // A set on the same edge as its clear wins, so no edge is ever lost.
    always_comb begin
        rise   = filt & ~filt_d_q;
        fall   = ~filt & filt_d_q;
        set    = (rise & cfg_irq_rise) | (fall & cfg_irq_fall);
        pend_d = (pend_q & ~irq_clear) | set;
        irq_d  = |pend_d;
    end

    always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
        if (!io_sys_reset) begin
            pad_o_q  <= '0;
            pad_t_q  <= '1;
            filt_d_q <= '0;
            pend_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            pad_o_q  <= pad_o_d;
            pad_t_q  <= pad_t_d;
            filt_d_q <= filt;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
        end
    end

    assign pins_read   = filt;
    assign pad_o       = pad_o_q;
    assign pad_t       = pad_t_q;
    assign irq_pending = pend_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed and randomized bench for gpio_pad_bank against a sample-history reference model.
module tb_gpio_pad_bank;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int FB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  pins_write = '0;
    logic [W-1:0]  pins_writeEnable = '0;
    logic [W-1:0]  pins_read;
    logic [2*W-1:0] cfg_mode = '0;
    logic [FB-1:0] cfg_filter = '0;
    logic [W-1:0]  cfg_irq_rise = '0;
    logic [W-1:0]  cfg_irq_fall = '0;
    logic [W-1:0]  irq_clear = '0;
    logic [W-1:0]  irq_pending;
    logic          irq;
    logic [W-1:0]  pad_i = 8'hFF;
    logic [W-1:0]  pad_o;
    logic [W-1:0]  pad_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0] hist[$];
    logic [W-1:0] m_read, m_read_prev, m_pend, m_pad_o, m_pad_t;
    logic         m_irq;

    always #5 clk = ~clk;

    gpio_pad_bank #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_BITS(FB)) dut (
        .io_sys_clock    (clk),
        .io_sys_reset    (rst_n),
        .pins_write      (pins_write),
        .pins_writeEnable(pins_writeEnable),
        .pins_read       (pins_read),
        .cfg_mode        (cfg_mode),
        .cfg_filter      (cfg_filter),
        .cfg_irq_rise    (cfg_irq_rise),
        .cfg_irq_fall    (cfg_irq_fall),
        .irq_clear       (irq_clear),
        .irq_pending     (irq_pending),
        .irq             (irq),
        .pad_i           (pad_i),
        .pad_o           (pad_o),
        .pad_t           (pad_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_read = '0; m_read_prev = '0; m_pend = '0; m_irq = 1'b0;
        m_pad_o = '0; m_pad_t = '1;
    endtask

    // A pin's read value flips once its last N synchronised samples (pad sampled S edges
    // earlier) all disagree with it; pending latches a reported edge one clock later.
    task automatic model_edge();
        int n, k, idx;
        logic [W-1:0] nxt;
        logic v, all_diff;
        n = (cfg_filter == 0) ? 1 : int'(cfg_filter);
        hist.push_back(pad_i);
        k = hist.size() - 1;
        m_pend = (m_pend & ~irq_clear)
               | (m_read & ~m_read_prev & cfg_irq_rise)
               | (~m_read & m_read_prev & cfg_irq_fall);
        m_irq = (m_pend != 0);
        nxt = m_read;
        for (int p = 0; p < W; p++) begin
            all_diff = 1'b1;
            for (int j = 0; j < n; j++) begin
                idx = k - S - j;
                v = (idx >= 0) ? hist[idx][p] : 1'b0;
                if (v == m_read[p]) all_diff = 1'b0;
            end
            if (all_diff) nxt[p] = ~m_read[p];
        end
        m_read_prev = m_read;
        m_read = nxt;
        for (int p = 0; p < W; p++) begin
            case (cfg_mode[2*p +: 2])
                2'b01:   begin m_pad_o[p] = pins_write[p]; m_pad_t[p] = ~pins_writeEnable[p]; end
                2'b10:   begin m_pad_o[p] = 1'b0; m_pad_t[p] = !(pins_writeEnable[p] && !pins_write[p]); end
                default: begin m_pad_o[p] = 1'b0; m_pad_t[p] = 1'b1; end
            endcase
        end
    endtask

    task automatic compare_all();
        check("pad_o", pad_o, m_pad_o);
        check("pad_t", pad_t, m_pad_t);
        check("pins_read", pins_read, m_read);
        check("irq_pending", irq_pending, m_pend);
        check("irq", irq, m_irq);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pad_t", pad_t, 8'hFF);
        check("arst_pad_o", pad_o, 8'h00);
        check("arst_read", pins_read, 8'h00);
        check("arst_pending", irq_pending, 8'h00);
        check("arst_irq", irq, 1'b0);
        model_reset();
        hold_reset(2);
    endtask

    initial begin
        model_reset();
        // Reset with all pads high and no interrupt enables
        hold_reset(3);
        check("rst_pad_t", pad_t, 8'hFF);
        check("rst_pad_o", pad_o, 8'h00);
        cycles(2);
        check("read_before_sync", pins_read, 8'h00);
        cycle();
        check("read_after_sync", pins_read, 8'hFF);
        cycles(2);
        check("no_pending_after_reset", irq_pending, 8'h00);

        // Push-pull on pin 0
        cfg_mode[1:0] = 2'b01; pins_write[0] = 1'b1; pins_writeEnable[0] = 1'b1;
        cycle();
        check("pp_t0", pad_t[0], 1'b0);
        check("pp_o0", pad_o[0], 1'b1);
        pins_writeEnable[0] = 1'b0;
        cycle();
        check("pp_t0_off", pad_t[0], 1'b1);

        // Open-drain on pin 1
        cfg_mode[3:2] = 2'b10; pins_write[1] = 1'b1; pins_writeEnable[1] = 1'b1;
        cycle();
        check("od_high_t1", pad_t[1], 1'b1);
        pins_write[1] = 1'b0;
        cycle();
        check("od_low_t1", pad_t[1], 1'b0);
        check("od_low_o1", pad_o[1], 1'b0);
        pins_writeEnable[1] = 1'b0;
        cycle();
        check("od_off_t1", pad_t[1], 1'b1);

        // Glitch filter with N=4 on pin 2
        cfg_filter = 4'd4;
        cycles(2);
        pad_i[2] = 1'b0;
        cycles(3);
        pad_i[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("pulse3_read2", pins_read[2], 1'b1);
        end
        pad_i[2] = 1'b0;
        cycles(4);
        pad_i[2] = 1'b1;
        cycle();
        check("pulse4_edge5_read2", pins_read[2], 1'b1);
        cycle();
        check("pulse4_edge6_read2", pins_read[2], 1'b0);
        cycles(8);
        check("pulse4_back_read2", pins_read[2], 1'b1);

        // Rising-edge interrupt on pin 3
        cfg_irq_rise = 8'h08;
        pad_i[3] = 1'b0;
        cycles(8);
        check("fall_no_pending", irq_pending, 8'h00);
        pad_i[3] = 1'b1;
        cycles(6);
        check("rise_pre_pending", irq_pending[3], 1'b0);
        cycle();
        check("rise_pending3", irq_pending[3], 1'b1);
        check("rise_irq", irq, 1'b1);
        pad_i[3] = 1'b0;
        cycles(8);
        check("pending_sticky", irq_pending[3], 1'b1);
        pad_i[3] = 1'b1;
        cycles(6);
        irq_clear = 8'h08;
        cycle();
        irq_clear = 8'h00;
        check("set_beats_clear", irq_pending[3], 1'b1);
        irq_clear = 8'h08;
        cycle();
        irq_clear = 8'h00;
        check("clear_pending", irq_pending, 8'h00);
        check("clear_irq", irq, 1'b0);

        // Asynchronous reset mid-filter with a pending interrupt
        pad_i[3] = 1'b0;
        cycles(8);
        pad_i[3] = 1'b1;
        cycles(7);
        check("pre_arst_pending", irq_pending, 8'h08);
        pad_i[2] = 1'b0;
        cycles(4);
        check("pre_arst_read2", pins_read[2], 1'b1);
        async_reset();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                cfg_filter   = FB'($urandom_range(0, 6));
                cfg_mode     = (2*W)'($urandom);
                cfg_irq_rise = W'($urandom);
                cfg_irq_fall = W'($urandom);
            end
            pins_write       = W'($urandom);
            pins_writeEnable = W'($urandom);
            irq_clear        = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            for (int p = 0; p < W; p++)
                if ($urandom_range(0, 3) == 0) pad_i[p] = ~pad_i[p];
            if (c == 700) async_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
